// File: rtl/buffer_reader.sv
// ============================================================================
//  Module   : buffer_reader
//  Purpose  : Drains a registered-head FIFO into a framed, strobed word stream
//             with optional inter-word gap, backpressure and boundary halt.
//             Define BUFFER_READER_COUNT_EN to build the word_count register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module buffer_reader #(
    parameter int WIDTH       = 32,
    parameter int PKT_LEN     = 16,
    parameter int LOG_PKT_LEN = 4,
    parameter int GAP         = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_full,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_delete,
    input  logic             out_ready,
    input  logic             halt,
    output logic             out_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             halted,
    output logic [31:0]      word_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_GAP    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [LOG_PKT_LEN-1:0] c_pkt_last = LOG_PKT_LEN'(PKT_LEN - 1);
    localparam logic [7:0]             c_gap_load = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LOG_PKT_LEN-1:0] r_pkt_cnt;
    logic [LOG_PKT_LEN-1:0] w_pkt_cnt_nxt;
    logic [7:0]             r_gap_cnt;
    logic [7:0]             w_gap_cnt_nxt;
    logic                   w_take;
    logic                   w_pkt_first;
    logic                   w_pkt_last;

    logic                   r_out_nd;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_first;
    logic                   r_out_last;

    assign w_pkt_first = (r_pkt_cnt == '0);
    assign w_pkt_last  = (r_pkt_cnt == c_pkt_last);

    // The stale-head cycle after a take only matters when GAP>0, and then the
    // GAP (or HALTED) state already occupies it, so no separate block flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_take        = 1'b0;
        case (r_state)
            S_RUN: begin
                w_take = in_full && out_ready;
                if (w_take) begin
                    w_pkt_cnt_nxt = w_pkt_last ? '0 : r_pkt_cnt + 1'b1;
                    if (halt && w_pkt_last) begin
                        w_state_nxt = S_HALTED;
                    end else if (GAP > 0) begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = c_gap_load;
                    end
                end else if (halt && w_pkt_first) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            S_HALTED: begin
                if (!halt) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_pkt_cnt   <= '0;
            r_gap_cnt   <= 8'd0;
            r_out_nd    <= 1'b0;
            r_out_data  <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pkt_cnt   <= w_pkt_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_out_nd    <= w_take;
            r_out_first <= w_take && w_pkt_first;
            r_out_last  <= w_take && w_pkt_last;
            if (w_take) begin
                r_out_data <= in_data;
            end
        end
    end

    // Gated with reset so the buffer is never popped while the block is held.
    assign in_delete = w_take && rst_n;
    assign out_nd    = r_out_nd;
    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign halted    = (r_state == S_HALTED);

`ifdef BUFFER_READER_COUNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= 32'd0;
        end else if (w_take) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`else
    assign word_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buffer_reader.sv
// ============================================================================
//  Module   : tb_buffer_reader
//  Purpose  : Drives two buffer_reader instances (GAP=0/PKT_LEN=16 and
//             GAP=3/PKT_LEN=5) from queue-modelled FIFOs; randomized stimulus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_buffer_reader;

    localparam int W   = 32;
    localparam int PL0 = 16;
    localparam int LG0 = 4;
    localparam int GP0 = 0;
    localparam int PL1 = 5;
    localparam int LG1 = 3;
    localparam int GP1 = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           out_ready = 1'b0;
    logic           halt = 1'b0;
    logic           in_full    [2];
    logic [W-1:0]   in_data    [2];
    logic           in_delete  [2];
    logic           out_nd     [2];
    logic [W-1:0]   out_data   [2];
    logic           out_first  [2];
    logic           out_last   [2];
    logic           halted     [2];
    logic [31:0]    word_count [2];

    always #5 clk = ~clk;

    buffer_reader #(.WIDTH(W), .PKT_LEN(PL0), .LOG_PKT_LEN(LG0), .GAP(GP0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_full(in_full[0]), .in_data(in_data[0]),
        .in_delete(in_delete[0]), .out_ready(out_ready), .halt(halt),
        .out_nd(out_nd[0]), .out_data(out_data[0]), .out_first(out_first[0]),
        .out_last(out_last[0]), .halted(halted[0]), .word_count(word_count[0])
    );

    buffer_reader #(.WIDTH(W), .PKT_LEN(PL1), .LOG_PKT_LEN(LG1), .GAP(GP1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_full(in_full[1]), .in_data(in_data[1]),
        .in_delete(in_delete[1]), .out_ready(out_ready), .halt(halt),
        .out_nd(out_nd[1]), .out_data(out_data[1]), .out_first(out_first[1]),
        .out_last(out_last[1]), .halted(halted[1]), .word_count(word_count[1])
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] fifo0[$];
    logic [W-1:0] fifo1[$];
    logic [W-1:0] next_word = '0;

    // Reference model: packet position, cycles since last take, halted flag
    int           m_pos   [2];
    int           m_since [2];
    bit           m_halt  [2];
    logic [W-1:0] m_data  [2];
    logic [31:0]  m_count [2];

    function automatic int pl(input int i);
        return (i == 0) ? PL0 : PL1;
    endfunction

    function automatic int gp(input int i);
        return (i == 0) ? GP0 : GP1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]   = 0;
            m_since[i] = 1000;
            m_halt[i]  = 1'b0;
            m_data[i]  = '0;
            m_count[i] = 32'd0;
        end
    endtask

    task automatic push_word();
        fifo0.push_back(next_word);
        fifo1.push_back(next_word);
        next_word = next_word + 1;
    endtask

    task automatic refresh_head();
        in_full[0] = (fifo0.size() > 0);
        in_data[0] = (fifo0.size() > 0) ? fifo0[0] : W'($urandom);
        in_full[1] = (fifo1.size() > 0);
        in_data[1] = (fifo1.size() > 0) ? fifo1[0] : W'($urandom);
    endtask

    task automatic check_zero();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_nd%0d", i),    32'(out_nd[i]),    32'd0);
            check($sformatf("rst_data%0d", i),  out_data[i],       32'd0);
            check($sformatf("rst_first%0d", i), 32'(out_first[i]), 32'd0);
            check($sformatf("rst_last%0d", i),  32'(out_last[i]),  32'd0);
            check($sformatf("rst_halt%0d", i),  32'(halted[i]),    32'd0);
            check($sformatf("rst_cnt%0d", i),   word_count[i],     32'd0);
            check($sformatf("rst_del%0d", i),   32'(in_delete[i]), 32'd0);
        end
    endtask

    // One clock: predict takes, compare in_delete, clock, compare outputs, update buffers
    task automatic step(input int n_push);
        bit           tk [2];
        logic [W-1:0] hd [2];
        logic [31:0]  exp_cnt;
        #1;
        for (int i = 0; i < 2; i++) begin
            tk[i] = !m_halt[i] && (m_since[i] > gp(i)) && in_full[i] && out_ready;
            hd[i] = in_data[i];
            check($sformatf("delete%0d", i), 32'(in_delete[i]), 32'(tk[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (tk[i]) begin
                m_data[i]  = hd[i];
                m_count[i] = m_count[i] + 32'd1;
            end
            check($sformatf("nd%0d", i),    32'(out_nd[i]),    32'(tk[i]));
            check($sformatf("first%0d", i), 32'(out_first[i]), 32'(tk[i] && m_pos[i] == 0));
            check($sformatf("last%0d", i),  32'(out_last[i]),  32'(tk[i] && m_pos[i] == pl(i) - 1));
            check($sformatf("data%0d", i),  out_data[i],       m_data[i]);
            if (m_halt[i]) begin
                if (!halt) begin
                    m_halt[i]  = 1'b0;
                    m_since[i] = 1000;
                end
            end else if (tk[i]) begin
                if (halt && m_pos[i] == pl(i) - 1) m_halt[i] = 1'b1;
                m_pos[i]   = (m_pos[i] + 1) % pl(i);
                m_since[i] = 1;
            end else begin
                if (m_since[i] > gp(i) && m_pos[i] == 0 && halt) m_halt[i] = 1'b1;
                if (m_since[i] < 1000) m_since[i]++;
            end
            check($sformatf("halted%0d", i), 32'(halted[i]), 32'(m_halt[i]));
`ifdef BUFFER_READER_COUNT_EN
            exp_cnt = m_count[i];
`else
            exp_cnt = 32'd0;
`endif
            check($sformatf("count%0d", i), word_count[i], exp_cnt);
        end
        if (tk[0]) void'(fifo0.pop_front());
        if (tk[1]) void'(fifo1.pop_front());
        for (int k = 0; k < n_push; k++) push_word();
        refresh_head();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 40; k++) push_word();
        refresh_head();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero();
        rst_n = 1'b1;

        // continuous stream of 0..39
        repeat (170) step(0);

        // backpressure mid-stream
        for (int k = 0; k < 20; k++) push_word();
        refresh_head();
        repeat (7) step(0);
        out_ready = 1'b0;
        repeat (10) step(0);
        out_ready = 1'b1;
        repeat (90) step(0);

        // halt requested mid-packet
        for (int k = 0; k < 30; k++) push_word();
        refresh_head();
        repeat (5) step(0);
        halt = 1'b1;
        repeat (30) step(0);
        halt = 1'b0;
        repeat (130) step(0);

        // underrun then a single late word
        repeat (20) step(0);
        step(1);
        repeat (10) step(0);

        // reset mid-packet
        for (int k = 0; k < 20; k++) push_word();
        refresh_head();
        repeat (9) step(0);
        pulse_reset();
        repeat (80) step(0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) halt = ~halt;
            if (n == 1500) pulse_reset();
            step(($urandom_range(0, 99) < 55) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
